// File: rtl/l1_cache_pkg.sv
// Shared types for the L1 line transfer sequencer: transfer op, FSM states
// and the words-per-line helper.
package l1_cache_pkg;

  typedef enum logic {
    XFER_FILL  = 1'b0,
    XFER_EVICT = 1'b1
  } xfer_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_EVICT = 2'd2,
    ST_DONE  = 2'd3
  } xfer_state_e;

  localparam int DEFAULT_LINE_BYTES = 16;

  // A line narrower than one word still counts as a single word.
  function automatic int words_per_line(input int line_bytes);
    return (line_bytes / 4 > 0) ? line_bytes / 4 : 1;
  endfunction

endpackage

// File: rtl/l1_line_xfer_ctrl.sv
// Moves whole L1 lines between the data array and the memory side (fills and evictions).
// Optional feature macro: L1_XFER_CRITICAL_WORD_FIRST_EN (fills start at req_word).
//
// Handshakes: a request transfers on the edge where req_valid && req_ready; a fill
// beat transfers on mem_rvalid && mem_rready; an evict beat on wb_valid && wb_ready.
// Valid/data never depend on the same-cycle ready of their own channel.
module l1_line_xfer_ctrl
  import l1_cache_pkg::*;
#(
  parameter int NUM_SETS      = 64,
  parameter int NUM_WAYS      = 4,
  parameter int LINE_BYTES    = DEFAULT_LINE_BYTES,
  parameter int INDEX_BITS    = $clog2(NUM_SETS),
  parameter int WAY_BITS      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int WORD_SEL_BITS = (LINE_BYTES > 4) ? $clog2(LINE_BYTES / 4) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_op,
  input  logic [INDEX_BITS-1:0]    req_index,
  input  logic [WAY_BITS-1:0]      req_way,
  input  logic [WORD_SEL_BITS-1:0] req_word,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     mem_rready,
  output logic                     wb_valid,
  output logic [31:0]              wb_data,
  output logic                     wb_last,
  input  logic                     wb_ready,
  output logic                     da_we,
  output logic [INDEX_BITS-1:0]    da_index,
  output logic [WAY_BITS-1:0]      da_way,
  output logic [WORD_SEL_BITS-1:0] da_word_sel,
  output logic [31:0]              da_wdata,
  input  logic [31:0]              da_rdata,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int WPL   = words_per_line(LINE_BYTES);
  localparam int CNT_W = WORD_SEL_BITS + 1;

  xfer_state_e              state_q, state_d;
  logic [INDEX_BITS-1:0]    index_q, index_d;
  logic [WAY_BITS-1:0]      way_q, way_d;
  logic [WORD_SEL_BITS-1:0] start_q, start_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [WORD_SEL_BITS-1:0] req_start_word;
  logic [WORD_SEL_BITS-1:0] cur_word;
  logic                     last_beat;

`ifdef L1_XFER_CRITICAL_WORD_FIRST_EN
  assign req_start_word = (xfer_op_e'(req_op) == XFER_EVICT) ? '0 : req_word;
`else
  logic unused_req_word;
  assign unused_req_word = ^req_word;
  assign req_start_word  = '0;
`endif

  // Truncating add gives the wrap through word 0 for power-of-two lines.
  assign cur_word  = start_q + cnt_q[WORD_SEL_BITS-1:0];
  assign last_beat = (cnt_q == CNT_W'(WPL - 1));
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      way_q   <= '0;
      start_q <= '0;
      cnt_q   <= '0;
    end else begin
      index_q <= index_d;
      way_q   <= way_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    way_d   = way_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          index_d = req_index;
          way_d   = req_way;
          start_d = req_start_word;
          cnt_d   = '0;
          state_d = (xfer_op_e'(req_op) == XFER_EVICT) ? ST_EVICT : ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_EVICT: begin
        if (wb_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // mem_rvalid->da_we and da_rdata->wb_data are intentionally combinational.
  always_comb begin
    req_ready   = 1'b0;
    mem_rready  = 1'b0;
    wb_valid    = 1'b0;
    wb_data     = '0;
    wb_last     = 1'b0;
    da_we       = 1'b0;
    da_index    = '0;
    da_way      = '0;
    da_word_sel = '0;
    da_wdata    = '0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_FILL: begin
        mem_rready  = 1'b1;
        da_index    = index_q;
        da_way      = way_q;
        da_word_sel = cur_word;
        if (mem_rvalid) begin
          da_we    = 1'b1;
          da_wdata = mem_rdata;
        end
      end
      ST_EVICT: begin
        wb_valid    = 1'b1;
        wb_data     = da_rdata;
        wb_last     = last_beat;
        da_index    = index_q;
        da_way      = way_q;
        da_word_sel = cur_word;
      end
      ST_DONE: begin
        done     = 1'b1;
        da_index = index_q;
        da_way   = way_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_line_xfer_ctrl.sv
// Directed bench for l1_line_xfer_ctrl with a behavioural data array alongside.
// Honours L1_XFER_CRITICAL_WORD_FIRST_EN for the expected fill order.
module tb_l1_line_xfer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [5:0]  req_index;
  logic [1:0]  req_way;
  logic [1:0]  req_word;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        wb_last;
  logic        wb_ready;
  logic        da_we;
  logic [5:0]  da_index;
  logic [1:0]  da_way;
  logic [1:0]  da_word_sel;
  logic [31:0] da_wdata;
  logic [31:0] da_rdata;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  bit   [31:0] arr [0:1023];

  l1_line_xfer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_way(req_way), .req_word(req_word),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_last(wb_last), .wb_ready(wb_ready),
    .da_we(da_we), .da_index(da_index), .da_way(da_way),
    .da_word_sel(da_word_sel), .da_wdata(da_wdata), .da_rdata(da_rdata),
    .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural data array
  assign da_rdata = arr[{da_index, da_way, da_word_sel}];
  always @(posedge clk) begin
    if (da_we) arr[{da_index, da_way, da_word_sel}] <= da_wdata;
  end

  function automatic logic [31:0] rd(input logic [5:0] idx, input logic [1:0] way,
                                     input logic [1:0] word);
    return arr[{idx, way, word}];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive_req(input logic op, input logic [5:0] idx, input logic [1:0] way,
                           input logic [1:0] word);
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_way   = way;
    req_word  = word;
  endtask

  // No-stall fill: request, 4 beats, done.
  task automatic fill_line(input logic [5:0] idx, input logic [1:0] way,
                           input logic [31:0] base);
    drive_req(1'b0, idx, way, 2'd0);
    settle;
    chk("fill_req_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + i;
      settle;
      chk("fill_we", da_we, 1);
      chk("fill_word_sel", da_word_sel, i);
      tick;
    end
    mem_rvalid = 1'b0;
    settle;
    chk("fill_done", done, 1);
    tick;
  endtask

  logic [31:0] word_order [4];
  int          hs;
  logic        toggle;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_index = '0; req_way = '0;
    req_word = '0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;

    // reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_rready", mem_rready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_da_we", da_we, 0);
    chk("rst_done", done, 0);
    chk("rst_da_index", da_index, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick;

    // fill set 5 way 2, no stalls, done in cycle 5
    drive_req(1'b0, 6'd5, 2'd2, 2'd0);
    settle;
    chk("f1_req_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA0 + i;
      settle;
      chk("f1_mem_rready", mem_rready, 1);
      chk("f1_we", da_we, 1);
      chk("f1_word_sel", da_word_sel, i);
      chk("f1_index", da_index, 5);
      chk("f1_way", da_way, 2);
      chk("f1_wdata", da_wdata, 32'hA0 + i);
      chk("f1_req_ready_busy", req_ready, 0);
      tick;
    end
    mem_rvalid = 1'b0;
    settle;
    chk("f1_done_c5", done, 1);
    chk("f1_req_ready_c5", req_ready, 0);
    tick;
    chk("f1_done_c6", done, 0);
    chk("f1_req_ready_c6", req_ready, 1);
    for (int i = 0; i < 4; i++) chk("f1_array", rd(6'd5, 2'd2, i[1:0]), 32'hA0 + i);

    // fill set 6 way 1 with a 3-cycle gap after 2 beats
    drive_req(1'b0, 6'd6, 2'd1, 2'd0);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hB0 + i;
      settle; chk("f2_we", da_we, 1); tick;
    end
    mem_rvalid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      settle;
      chk("f2_gap_we", da_we, 0);
      chk("f2_gap_rready", mem_rready, 1);
      chk("f2_gap_done", done, 0);
      tick;
    end
    for (int i = 2; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hB0 + i;
      settle; chk("f2_word_sel", da_word_sel, i); tick;
    end
    mem_rvalid = 1'b0;
    settle;
    chk("f2_done_c8", done, 1);
    tick;
    for (int i = 0; i < 4; i++) chk("f2_array", rd(6'd6, 2'd1, i[1:0]), 32'hB0 + i);

    // preload set 63 way 3, then evict with wb_ready toggling
    fill_line(6'd63, 2'd3, 32'hC0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0 + i);
    drive_req(1'b1, 6'd63, 2'd3, 2'd0);
    tick;
    req_valid = 1'b0;
    hs = 0;
    toggle = 1'b0;
    for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
      wb_ready = toggle;
      settle;
      chk("ev_wb_valid", wb_valid, 1);
      chk("ev_wb_data", wb_data, exp_q[0]);
      chk("ev_wb_last", wb_last, (exp_q.size() == 1) ? 1 : 0);
      chk("ev_da_we", da_we, 0);
      if (wb_ready) begin
        void'(exp_q.pop_front());
        hs++;
      end
      toggle = ~toggle;
      tick;
    end
    wb_ready = 1'b0;
    chk("ev_handshakes", hs, 4);
    settle;
    chk("ev_done", done, 1);
    chk("ev_wb_valid_done", wb_valid, 0);
    tick;

    // fill set 7 way 0 with req_word=2
`ifdef L1_XFER_CRITICAL_WORD_FIRST_EN
    word_order = '{32'd2, 32'd3, 32'd0, 32'd1};
`else
    word_order = '{32'd0, 32'd1, 32'd2, 32'd3};
`endif
    drive_req(1'b0, 6'd7, 2'd0, 2'd2);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hD0 + i;
      settle; chk("cw_word_sel", da_word_sel, word_order[i]); tick;
    end
    mem_rvalid = 1'b0;
    settle; chk("cw_done", done, 1); tick;
    for (int i = 0; i < 4; i++)
      chk("cw_array", rd(6'd7, 2'd0, word_order[i][1:0]), 32'hD0 + i);

    // reset mid-fill after 2 beats
    drive_req(1'b0, 6'd8, 2'd1, 2'd0);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hE0 + i;
      settle; tick;
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hE2;
    rst_n = 1'b0;
    settle;
    chk("mr_req_ready", req_ready, 1);
    chk("mr_mem_rready", mem_rready, 0);
    chk("mr_da_we", da_we, 0);
    chk("mr_da_index", da_index, 0);
    chk("mr_done", done, 0);
    tick;
    rst_n = 1'b1;
    mem_rvalid = 1'b0;
    chk("mr_word0_kept", rd(6'd8, 2'd1, 2'd0), 32'hE0);
    chk("mr_word1_kept", rd(6'd8, 2'd1, 2'd1), 32'hE1);
    chk("mr_word2_unwritten", rd(6'd8, 2'd1, 2'd2), 32'h0);
    tick;
    fill_line(6'd9, 2'd0, 32'hF0);
    chk("mr_post_array", rd(6'd9, 2'd0, 2'd3), 32'hF3);

    // req_valid held across an evict; stray mem_rvalid ignored
    drive_req(1'b1, 6'd63, 2'd3, 2'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    wb_ready = 1'b1;
    settle;
    chk("hold_req_ready_c0", req_ready, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      settle;
      chk("hold_req_ready_busy", req_ready, 0);
      chk("hold_da_we", da_we, 0);
      chk("hold_wb_data", wb_data, 32'hC0 + i);
      tick;
    end
    settle;
    chk("hold_done", done, 1);
    chk("hold_req_ready_done", req_ready, 0);
    tick;
    chk("hold_req_ready_c6", req_ready, 1);
    tick;
    req_valid = 1'b0;
    settle;
    chk("hold_second_wb_valid", wb_valid, 1);
    chk("hold_second_wb_data", wb_data, 32'hC0);
    for (int i = 0; i < 4; i++) tick;
    settle;
    chk("hold_second_done", done, 1);
    tick;
    wb_ready = 1'b0;
    mem_rdata = 32'hFF;
    settle;
    chk("idle_rvalid_we", da_we, 0);
    chk("idle_rvalid_rready", mem_rready, 0);
    tick;
    chk("idle_array_untouched", rd(6'd0, 2'd0, 2'd0), 32'h0);
    chk("hold_array_intact", rd(6'd63, 2'd3, 2'd2), 32'hC2);
    mem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
